// File: rtl/line_transfer_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : line_transfer_engine
// Description : AXI4 master moving one cache line per request as a single
//               INCR burst (write-back from, or fill into, the data array).
// Revision    : 1.0 - initial release
// ============================================================================
module line_transfer_engine #(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int DATA_WIDTH = 32,
  localparam int BEATS  = ((2 ** BLOCK_SIZE) * 8) / DATA_WIDTH,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  // controller request / completion
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_SIZE-1:0]      req_addr,
  output logic                      done,
  output logic                      err,
  // data array line port
  output logic [BEAT_W-1:0]         line_idx,
  input  logic [DATA_WIDTH-1:0]     line_rdata,
  output logic                      fill_we,
  output logic [BEAT_W-1:0]         fill_idx,
  output logic [DATA_WIDTH-1:0]     fill_data,
  // AXI write address channel
  output logic [ADDR_SIZE-1:0]      awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  // AXI write response channel
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AXI read address channel
  output logic [ADDR_SIZE-1:0]      araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  // AXI read data channel
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam logic [7:0]        AXI_LEN   = 8'(BEATS - 1);
  localparam logic [2:0]        AXI_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0]        AXI_INCR  = 2'b01;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_SIZE-1:0]  addr_q,  addr_d;
  logic [BEAT_W-1:0]     cnt_q,   cnt_d;
  logic                  err_q,   err_d;
  // set once a read beat has arrived past the end of the line without rlast
  logic                  over_q,  over_d;
  logic                  last_beat;

  // response bit 0 only separates OKAY/EXOKAY and SLVERR/DECERR
  logic unused_bits;
  assign unused_bits = ^{bresp[0], rresp[0], req_addr[BLOCK_SIZE-1:0]};

  assign last_beat = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    over_d    = over_q;
    req_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    fill_we   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          addr_d  = {req_addr[ADDR_SIZE-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
          cnt_d   = '0;
          err_d   = 1'b0;
          over_d  = 1'b0;
          state_d = req_write ? ST_AW : ST_AR;
        end
      end

      ST_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = ST_W;
      end

      ST_W: begin
        wvalid = 1'b1;
        wlast  = last_beat;
        if (wready) begin
          cnt_d = cnt_q + BEAT_W'(1);
          if (last_beat) state_d = ST_B;
        end
      end

      ST_B: begin
        bready = 1'b1;
        if (bvalid) begin
          if (bresp[1]) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end

      ST_R: begin
        rready  = 1'b1;
        fill_we = rvalid & ~over_q;
        if (rvalid) begin
          if (rresp[1]) err_d = 1'b1;
          if (rlast) begin
            if (over_q || !last_beat) err_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            // a missing rlast on the final beat is an error; keep draining
            if (over_q || last_beat) begin
              err_d  = 1'b1;
              over_d = 1'b1;
            end
            if (!over_q) cnt_d = cnt_q + BEAT_W'(1);
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign awaddr    = addr_q;
  assign awlen     = AXI_LEN;
  assign awsize    = AXI_SIZE;
  assign awburst   = AXI_INCR;
  assign araddr    = addr_q;
  assign arlen     = AXI_LEN;
  assign arsize    = AXI_SIZE;
  assign arburst   = AXI_INCR;
  assign line_idx  = cnt_q;
  assign wdata     = line_rdata;
  assign wstrb     = '1;
  assign fill_idx  = cnt_q;
  assign fill_data = rdata;

endmodule
`default_nettype wire
